// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target receiver state encoding, R/W bit value and
// a small byte-assembly helper used by both the target receiver and the
// write controller.
package i2c_pkg;

  // Target receiver FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_ACK_A  = 3'd2,
    ST_DATA   = 3'd3,
    ST_ACK_D  = 3'd4,
    ST_IGNORE = 3'd5
  } i2c_tgt_state_t;

  // Value of the R/W bit for a write transfer
  localparam logic I2C_RW_WRITE = 1'b0;

  // Index of the last bit in a byte (bits are counted 0..7)
  localparam logic [2:0] I2C_LAST_BIT = 3'd7;

  // Shift one bus bit into a byte, MSB first
  function automatic logic [7:0] i2c_shift_in(input logic [7:0] cur, input logic b);
    return {cur[6:0], b};
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronizer plus edge detector for one raw I2C pin. All flops reset to 1,
// which is the idle level of an open-drain bus line, so leaving reset never
// produces a spurious edge.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  // First synchronizer stage samples the raw pin
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_reg[0] <= 1'b1;
    else          sync_reg[0] <= d;
  end

  genvar gi;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_stage
      // Remaining synchronizer stages, one flop each
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_reg[gi] <= 1'b1;
        else          sync_reg[gi] <= sync_reg[gi-1];
      end
    end
  endgenerate

  // Previous-value flop for edge detection on the synchronized signal
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev_reg <= 1'b1;
    else          prev_reg <= sync_reg[SYNC_STAGES-1];
  end

  assign q    = sync_reg[SYNC_STAGES-1];
  assign rise =  q & ~prev_reg;
  assign fall = ~q &  prev_reg;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target receiver. Oversamples SCL/SDA, decodes START/STOP,
// matches the 7-bit address, ACKs by pulling SDA low and collects NBYTES data
// bytes onto a parallel bus. SCL is never driven or stretched.
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR        = 7'h10,
  parameter int         NBYTES      = 2,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   SCL,
  input  logic                   SDA,
  output logic                   SDA_OE,
  output logic [NBYTES-1:0][7:0] rdata,
  output logic                   valid,
  output logic                   busy
);

  localparam int                BYTE_W   = $clog2(NBYTES + 1);
  localparam logic [BYTE_W-1:0] NBYTES_C = BYTE_W'(NBYTES);

  logic scl_q, scl_rise, scl_fall;
  logic sda_q, sda_rise, sda_fall;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (SCL),
    .q       (scl_q),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (SDA),
    .q       (sda_q),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  i2c_tgt_state_t              state_reg;
  logic [2:0]                  bit_cnt_reg;
  logic [BYTE_W-1:0]           byte_cnt_reg;
  logic [7:0]                  shift_reg;
  logic                        sda_oe_reg;
  logic                        valid_reg;
  logic                        busy_reg;
  logic [NBYTES-1:0][7:0]      rdata_reg;

  logic       start_evt;
  logic       stop_evt;
  logic [7:0] byte_next;
  logic       addr_match;
  logic       store_en;

  // Bus conditions: SDA changing while SCL is high
  assign start_evt = sda_fall & scl_q;
  assign stop_evt  = sda_rise & scl_q;

  // Byte as it stands once the current SDA level is shifted in
  assign byte_next  = i2c_shift_in(shift_reg, sda_q);
  assign addr_match = (byte_next[7:1] == ADDR) && (byte_next[0] == I2C_RW_WRITE);

  // A data byte is latched on its 8th SCL rise while there is room for it
  assign store_en = (state_reg == ST_DATA) && scl_rise && !start_evt && !stop_evt &&
                    (bit_cnt_reg == I2C_LAST_BIT) && (byte_cnt_reg < NBYTES_C);

  // Protocol FSM with counters and registered SDA_OE / valid / busy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      bit_cnt_reg  <= 3'd0;
      byte_cnt_reg <= '0;
      shift_reg    <= 8'h00;
      sda_oe_reg   <= 1'b0;
      valid_reg    <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      if (stop_evt) begin
        state_reg  <= ST_IDLE;
        sda_oe_reg <= 1'b0;
        busy_reg   <= 1'b0;
      end else if (start_evt) begin
        // START from idle and repeated START mid-transfer behave the same
        state_reg    <= ST_ADDR;
        sda_oe_reg   <= 1'b0;
        busy_reg     <= 1'b1;
        bit_cnt_reg  <= 3'd0;
        byte_cnt_reg <= '0;
      end else begin
        case (state_reg)
          ST_ADDR: begin
            if (scl_rise) begin
              shift_reg <= byte_next;
              if (bit_cnt_reg == I2C_LAST_BIT) begin
                state_reg <= addr_match ? ST_ACK_A : ST_IGNORE;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
              end
            end
          end
          ST_ACK_A, ST_ACK_D: begin
            // First fall drives the ACK, second fall releases it
            if (scl_fall) begin
              if (!sda_oe_reg) begin
                sda_oe_reg <= 1'b1;
              end else begin
                sda_oe_reg  <= 1'b0;
                state_reg   <= ST_DATA;
                bit_cnt_reg <= 3'd0;
                if ((state_reg == ST_ACK_D) && (byte_cnt_reg == NBYTES_C)) valid_reg <= 1'b1;
              end
            end
          end
          ST_DATA: begin
            if (scl_rise) begin
              shift_reg <= byte_next;
              if (bit_cnt_reg == I2C_LAST_BIT) begin
                if (byte_cnt_reg < NBYTES_C) begin
                  byte_cnt_reg <= byte_cnt_reg + BYTE_W'(1);
                  state_reg    <= ST_ACK_D;
                end else begin
                  // Extra byte beyond NBYTES: NACK and wait for the bus to end
                  state_reg <= ST_IGNORE;
                end
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
              end
            end
          end
          ST_IDLE, ST_IGNORE: begin
            sda_oe_reg <= 1'b0;
          end
          default: begin
            state_reg  <= ST_IDLE;
            sda_oe_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_rdata
      // First received byte lands in the top slot, later bytes fill downwards
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rdata_reg[gi] <= 8'h00;
        end else if (store_en && (byte_cnt_reg == BYTE_W'(NBYTES - 1 - gi))) begin
          rdata_reg[gi] <= byte_next;
        end
      end
    end
  endgenerate

  assign SDA_OE = sda_oe_reg;
  assign valid  = valid_reg;
  assign busy   = busy_reg;
  assign rdata  = rdata_reg;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: a bit-banged I2C master drives an open-drain bus
// model, and a transaction-level reference decides ACKs, valid pulses and the
// expected parallel data from the address/byte rules alone.
module tb_i2c_target_rx;

  localparam logic [6:0] ADDR_P = 7'h10;
  localparam int         NB     = 2;
  localparam int         Q      = 8;   // quarter SCL period in clk cycles

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              scl_m = 1'b1;
  logic              sda_m = 1'b1;
  logic              sda_pin;
  logic              sda_oe;
  logic              valid;
  logic              busy;
  logic [NB-1:0][7:0] rdata;

  int total = 0;
  int bad = 0;
  int valid_cnt = 0;

  logic [7:0] exp_byte [NB];
  logic [7:0] tx [4];

  assign sda_pin = sda_m & ~sda_oe;

  i2c_target_rx #(.ADDR(ADDR_P), .NBYTES(NB), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .SCL     (scl_m),
    .SDA     (sda_pin),
    .SDA_OE  (sda_oe),
    .rdata   (rdata),
    .valid   (valid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (valid === 1'b1) valid_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop(input bit check_busy, input string tag);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1;
    tick(2);
    if (check_busy) chk({tag, " busy before stop latency"}, 32'(busy), 32'd1);
    tick(1);
    chk({tag, " busy 3clk after stop"}, 32'(busy), 32'd0);
    tick(Q);
  endtask

  task automatic send_bit(input logic b, inout logic oe_seen);
    sda_m = b;     tick(Q);
    scl_m = 1'b1;  tick(Q);
    oe_seen = oe_seen | sda_oe;
    tick(Q);
    scl_m = 1'b0;  tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit exp_ack, input string tag);
    logic oe_seen;
    logic ack;
    oe_seen = 1'b0;
    for (int i = 7; i >= 0; i--) send_bit(b[i], oe_seen);
    chk({tag, " no drive during bits"}, 32'(oe_seen), 32'd0);
    sda_m = 1'b1;  tick(Q);
    scl_m = 1'b1;  tick(Q);
    ack = ~sda_pin;
    chk({tag, " ack"}, 32'(ack), 32'(exp_ack));
    tick(Q);
    scl_m = 1'b0;  tick(Q);
  endtask

  task automatic check_rdata(input string tag);
    for (int i = 0; i < NB; i++)
      chk($sformatf("%s rdata byte%0d", tag, i), 32'(rdata[NB-1-i]), 32'(exp_byte[i]));
  endtask

  // One complete transfer: START, address byte, nd data bytes from tx[], STOP
  task automatic xfer(input logic [7:0] ab, input int nd, input string tag);
    int  v0;
    bit  adr;
    bit  ok;
    v0 = valid_cnt;
    adr = (ab[7:1] == ADDR_P) && (ab[0] == 1'b0);
    bus_start();
    chk({tag, " busy after start"}, 32'(busy), 32'd1);
    send_byte(ab, adr, {tag, " addr"});
    for (int i = 0; i < nd; i++) begin
      ok = adr && (i < NB);
      send_byte(tx[i], ok, $sformatf("%s data%0d", tag, i));
      if (ok) exp_byte[i] = tx[i];
    end
    bus_stop(1'b1, tag);
    chk({tag, " valid pulses"}, 32'(valid_cnt - v0), (adr && nd >= NB) ? 32'd1 : 32'd0);
    check_rdata(tag);
    $display("xfer %s addr=%02h bytes=%0d rdata=%04h", tag, ab, nd, rdata);
  endtask

  // Abort mid-byte: START then k bits, leaving SCL low for a repeated START
  task automatic partial(input logic [7:0] b, input int k);
    logic dummy;
    dummy = 1'b0;
    bus_start();
    for (int i = 7; i > 7 - k; i--) send_bit(b[i], dummy);
  endtask

  initial begin
    int         r;
    int         nd;
    logic [7:0] ab;
    logic [7:0] rb;

    for (int i = 0; i < NB; i++) exp_byte[i] = 8'h00;

    tick(3);
    chk("reset SDA_OE", 32'(sda_oe), 32'd0);
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    check_rdata("reset");
    reset_n = 1'b1;
    tick(4);

    tx[0] = 8'h12; tx[1] = 8'h34;
    xfer(8'h20, 2, "t1_write");

    tx[0] = 8'hC3; tx[1] = 8'h5A;
    xfer(8'h22, 2, "t2_wrong_addr");

    tx[0] = 8'h99; tx[1] = 8'h66;
    xfer(8'h21, 2, "t3_read_bit");

    tx[0] = 8'hAB;
    xfer(8'h20, 1, "t4_partial");

    partial(8'h20, 4);
    tx[0] = 8'h55; tx[1] = 8'hAA;
    xfer(8'h20, 2, "t5_rstart");

    tx[0] = 8'h12; tx[1] = 8'h34; tx[2] = 8'h77;
    xfer(8'h20, 3, "t6_extra");

    for (int n = 0; n < 14; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 60)      ab = {ADDR_P, 1'b0};
      else if (r < 75) ab = {ADDR_P, 1'b1};
      else             ab = 8'($urandom);
      nd = int'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) tx[i] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        rb = 8'($urandom);
        partial(rb, int'($urandom_range(1, 7)));
      end
      xfer(ab, nd, $sformatf("rnd%0d", n));
    end

    // Reset while the target is driving its address ACK
    bus_start();
    begin
      logic dummy;
      dummy = 1'b0;
      for (int i = 7; i >= 0; i--) send_bit(rb_addr(i), dummy);
    end
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    chk("rst_ack SDA_OE driven", 32'(sda_oe), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ack SDA_OE released", 32'(sda_oe), 32'd0);
    chk("rst_ack busy", 32'(busy), 32'd0);
    for (int i = 0; i < NB; i++) exp_byte[i] = 8'h00;
    check_rdata("rst_ack");
    $display("xfer rst_ack reset asserted during ACK sda_oe=%0b", sda_oe);
    tick(2);
    reset_n = 1'b1;
    tick(Q);
    scl_m = 1'b0; tick(Q);
    bus_stop(1'b0, "rst_ack");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bits of the matching write address byte, MSB index 7
  function automatic logic rb_addr(input int i);
    logic [7:0] a;
    a = {ADDR_P, 1'b0};
    return a[i];
  endfunction

endmodule
